// File: rtl/regfile_write_queue.sv
// ============================================================================
// Module   : regfile_write_queue
// Purpose  : Circular write queue in front of a register file, with read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_register,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       drain_en,
  output logic                       WEn,
  output logic [ADDR_W-1:0]          write_register,
  output logic [DATA_W-1:0]          Write_data,
  input  logic [ADDR_W-1:0]          read1,
  input  logic [ADDR_W-1:0]          read2,
  input  logic [DATA_W-1:0]          Data1_rf,
  input  logic [DATA_W-1:0]          Data2_rf,
  output logic [DATA_W-1:0]          Data1,
  output logic [DATA_W-1:0]          Data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  idx;
  logic              push;
  logic              pop;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && (count != '0);

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= in_register;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      WEn            <= 1'b0;
      write_register <= '0;
      Write_data     <= '0;
    end else begin
      WEn <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        write_register <= reg_mem[rd_ptr];
        Write_data     <= data_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Oldest-to-newest scan: later matches override, so the newest pending write wins.
  always_comb begin
    Data1 = Data1_rf;
    Data2 = Data2_rf;
    idx   = '0;
    if (WEn && (read1 != '0) && (write_register == read1)) Data1 = Write_data;
    if (WEn && (read2 != '0) && (write_register == read2)) Data2 = Write_data;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((read1 != '0) && (reg_mem[idx] == read1)) Data1 = data_mem[idx];
        if ((read2 != '0) && (reg_mem[idx] == read2)) Data2 = data_mem[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
// Module   : tb_regfile_write_queue
// Purpose  : Directed scoreboard bench for regfile_write_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_register;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              WEn;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] read1, read2;
  logic [DATA_W-1:0] Data1_rf, Data2_rf, Data1, Data2;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;
  int mcount = 0;
  logic [ADDR_W+DATA_W-1:0] sbq [$];

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_register(in_register), .in_data(in_data), .drain_en(drain_en),
    .WEn(WEn), .write_register(write_register), .Write_data(Write_data),
    .read1(read1), .read2(read2), .Data1_rf(Data1_rf), .Data2_rf(Data2_rf),
    .Data1(Data1), .Data2(Data2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock edge: predict handshakes, advance the scoreboard, check outputs.
  task automatic tick();
    logic will_push, will_pop;
    logic [ADDR_W+DATA_W-1:0] pushed, exp;
    chk("in_ready", in_ready, (mcount < DEPTH));
    will_push = in_valid && (mcount < DEPTH);
    will_pop  = drain_en && (mcount != 0);
    pushed    = {in_register, in_data};
    @(posedge clk);
    #1;
    exp = '0;
    if (will_pop) begin
      if (sbq.size() != 0) exp = sbq.pop_front();
      mcount--;
    end
    if (will_push) begin
      sbq.push_back(pushed);
      mcount++;
    end
    chk("WEn", WEn, will_pop);
    chk("count", count, mcount);
    if (will_pop) begin
      chk("write_register", write_register, exp[ADDR_W+DATA_W-1:DATA_W]);
      chk("Write_data", Write_data, exp[DATA_W-1:0]);
    end
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_register = r; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_register = '0; in_data = '0; drain_en = 1'b0;
    read1 = '0; read2 = '0; Data1_rf = '0; Data2_rf = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_WEn", WEn, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_write_register", write_register, 0);
    chk("rst_Write_data", Write_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single push drains one edge later for exactly one cycle.
    drain_en = 1'b1;
    push_one(5'd5, 64'h6);
    tick();
    tick();

    // Fill, ignored fifth push, forwarding from a full queue, ordered drain.
    drain_en = 1'b0;
    for (int r = 3; r <= 6; r++) push_one(ADDR_W'(r), 64'h100 + 64'(r));
    chk("full_in_ready", in_ready, 0);
    push_one(5'd9, 64'h999);
    chk("full_count", count, 4);
    read1 = 5'd5; Data1_rf = 64'h0; #1;
    chk("fwd_full", Data1, 64'h105);
    drain_en = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Newest duplicate wins; queue plus in-flight forwarding; fallback after drain.
    drain_en = 1'b0;
    read1 = 5'd3; Data1_rf = 64'h0;
    push_one(5'd3, 64'hABCDFE);
    chk("fwd_first", Data1, 64'hABCDFE);
    push_one(5'd3, 64'h11);
    chk("fwd_newest", Data1, 64'h11);
    drain_en = 1'b1;
    tick();
    chk("fwd_q_over_inflight", Data1, 64'h11);
    tick();
    chk("fwd_inflight", Data1, 64'h11);
    tick();
    Data1_rf = 64'hDEAD; #1;
    chk("fwd_fallback", Data1, 64'hDEAD);

    // Concurrent push/pop with pointer wrap.
    drain_en = 1'b0;
    push_one(5'd20, 64'h2000);
    push_one(5'd21, 64'h2001);
    drain_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_register = ADDR_W'(k + 1); in_data = 64'h3000 + 64'(k);
      tick();
      chk("simul_count", count, 2);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Asynchronous reset while draining discards everything.
    drain_en = 1'b0;
    for (int r = 7; r <= 10; r++) push_one(ADDR_W'(r), 64'h700 + 64'(r));
    drain_en = 1'b1;
    tick();
    read2 = 5'd9; Data2_rf = 64'h5555; #1;
    chk("fwd2_pre_reset", Data2, 64'h709);
    rst = 1'b1; #2;
    chk("arst_WEn", WEn, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_Data2", Data2, 64'h5555);
    sbq.delete(); mcount = 0; drain_en = 1'b0;
    #2; rst = 1'b0;
    tick();
    chk("post_reset_Data2", Data2, 64'h5555);

    // Register 0 is queued and drained but never forwarded.
    read1 = 5'd0; Data1_rf = 64'h0;
    push_one(5'd0, 64'hFF);
    chk("r0_fwd_zero", Data1, 64'h0);
    Data1_rf = 64'h77; #1;
    chk("r0_passthrough", Data1, 64'h77);
    drain_en = 1'b1;
    tick();
    tick();
    chk("final_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter: DEPTH, 4, number of queued write entries (power of two, >=2).
REQ-003 Parameter: DATA_W, 64, register data width.
REQ-004 Parameter: ADDR_W, 5, register index width.
REQ-005 Ports SHALL be, one per line:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer write request valid
in_ready  out  1  queue can accept
in_register  in  ADDR_W  destination register index
in_data  in  DATA_W  destination data
drain_en  in  1  permit draining to the register file
WEn  out  1  register-file write enable
write_register  out  ADDR_W  register-file write index
Write_data  out  DATA_W  register-file write data
read1  in  ADDR_W  read index 1 (same value driven to the register file)
read2  in  ADDR_W  read index 2
Data1_rf  in  DATA_W  register-file read data 1
Data2_rf  in  DATA_W  register-file read data 2
Data1  out  DATA_W  forwarded read data 1
Data2  out  DATA_W  forwarded read data 2
count  out  clog2(DEPTH)+1  occupied queue entries

Function
REQ-006 The queue SHALL be a circular FIFO of DEPTH {register, data} entries with read and write pointers wrapping modulo DEPTH.
REQ-007 in_ready SHALL be combinational: 1 when count < DEPTH, else 0, independent of a same-cycle pop.
REQ-008 Push SHALL occur on a clk edge with in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored, and the producer holds its request.
REQ-009 Pop SHALL occur on a clk edge with drain_en && count != 0, and SHALL load the head entry into write_register/Write_data and set WEn=1 on that edge.
REQ-010 On any edge without a pop, WEn SHALL go to 0; write_register/Write_data SHALL hold their values.
REQ-011 No fall-through: an entry pushed on edge N SHALL be popped no earlier than edge N+1, so WEn is high at the earliest from N+1 to N+2.
REQ-012 Simultaneous push and pop SHALL leave count unchanged; push-only increments and pop-only decrements it.
REQ-013 Entries SHALL drain strictly in push order; duplicate register indices SHALL each be written.
REQ-014 The in-flight stage (WEn=1 with write_register/Write_data) SHALL count as a pending write for forwarding.
REQ-015 Data1 SHALL be the data of the newest pending write whose register equals read1, checking the newest queue entry first, then older entries, then the in-flight stage; with no match it SHALL be Data1_rf. Data2 follows the same rule with read2/Data2_rf.
REQ-016 Forwarding SHALL be combinational and SHALL treat read index 0 as never matching, so Data1_rf/Data2_rf pass through.
REQ-017 Writes to register 0 SHALL still be queued and drained; the register file defines how register 0 behaves.
REQ-018 A pushed entry SHALL be visible to forwarding from the edge it is pushed on.

Reset
REQ-019 While rst=1, count, both pointers, WEn, write_register and Write_data SHALL be 0, independent of clk.
REQ-020 Reset mid-operation SHALL discard all queued and in-flight entries; forwarding SHALL then return Data1_rf/Data2_rf.
REQ-021 in_ready SHALL be 1 during and after reset; entry storage need not be reset.

Verification
REQ-022 Reset, then push {5, 64'h6} with drain_en=1 -> count goes 1 then 0; WEn=1, write_register=5, Write_data=6 for exactly one cycle, starting one edge after the push.
REQ-023 With drain_en=0, push 4 entries (3, 4, 5, 6) -> in_ready=0 and count=4; a fifth push is ignored. Then drain_en=1 -> WEn is high for 4 cycles with registers 3, 4, 5, 6 in order.
REQ-024 With drain_en=0, push {3, 64'hABCDFE} then {3, 64'h11}, with read1=3 and Data1_rf=0 -> Data1=64'h11. After the full drain and deassertion of WEn -> Data1=Data1_rf.
REQ-025 With drain_en=1 and 2 queued entries, push and pop on the same edge -> count stays 2. Run 10 or more pushes so the pointers wrap -> order and data are preserved.
REQ-026 With 3 entries queued and WEn=1, assert rst asynchronously between edges -> WEn=0 and count=0 immediately; Data2 for a queued register returns Data2_rf.
REQ-027 Push {0, 64'hFF} with read1=0 and Data1_rf=0 -> Data1=0. The entry still drains with write_register=0 and WEn=1.
